reversi_flip_scan: RTL and testbench

Sequential move evaluator for the reversi board. On request it takes a snapshot of the 192-bit board, a target cell (x, y) and the side to move. It walks the eight directions one cell per clock and reports whether the move is legal, together with a 64-bit mask of the cells to reverse. It sits between the player-input path and the game-process FSM, which uses `valid` to leave its check state and `flip_mask` to drive the reverse step.

---
 rtl/reversi_flip_scan.sv | 247 ++++++++++++++++++++++++
 tb/tb_reversi_flip_scan.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reversi_flip_scan.sv
// ---------------------------------------------------------------------------
// reversi_flip_scan
//
// Sequential move evaluator for a reversi board. A start pulse in IDLE
// snapshots the 192-bit board, the target cell (x, y) and the side to move.
// The block then walks the eight directions, one cell per clock. It reports
// whether the move is legal and which cells the move reverses.
//
// Ports
//   clk         in   1    clock
//   resetn      in   1    synchronous, active-low reset
//   start       in   1    request pulse, sampled only in IDLE
//   board       in   192  cell n at [3n+2:3n], n = y*8+x
//                         codes: 000 empty, 100 enable, 110 white, 111 black
//   x, y        in   3    target column / row
//   set_black   in   1    side to move: 1 = black, 0 = white
//   busy        out  1    high in any state other than IDLE
//   done        out  1    one-cycle pulse; results are valid from this cycle
//   valid       out  1    move is legal
//   flip_mask   out  64   bit n set = cell n is reversed
//   flip_count  out  7    popcount of flip_mask
//
// Build option
//   REVERSI_FLIP_COUNT_EN  when defined, a run-length counter drives
//                          flip_count. When undefined, flip_count is tied to 0.
// ---------------------------------------------------------------------------
module reversi_flip_scan (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [191:0] board,
  input  logic [2:0]   x,
  input  logic [2:0]   y,
  input  logic         set_black,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [63:0]  flip_mask,
  output logic [6:0]   flip_count
);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t state_reg, state_next;

  logic [191:0]      board_reg;
  logic [2:0]        tx_reg, ty_reg;
  logic              black_reg;
  logic [2:0]        dir_reg;
  logic signed [3:0] cx_reg, cy_reg;
  logic [63:0]       acc_reg, run_reg;
  logic              valid_reg;
  logic [63:0]       mask_reg;

  // Strobes issued by the FSM and consumed by the datapath.
  logic load, step, commit, end_dir, finish, reject;

  // Direction vector for the current dir.
  logic signed [3:0] dx, dy;
  always_comb begin
    dx = 4'sd0;
    dy = 4'sd0;
    case (dir_reg)
      3'd0: begin dx =  4'sd0; dy = -4'sd1; end  // N
      3'd1: begin dx =  4'sd1; dy = -4'sd1; end  // NE
      3'd2: begin dx =  4'sd1; dy =  4'sd0; end  // E
      3'd3: begin dx =  4'sd1; dy =  4'sd1; end  // SE
      3'd4: begin dx =  4'sd0; dy =  4'sd1; end  // S
      3'd5: begin dx = -4'sd1; dy =  4'sd1; end  // SW
      3'd6: begin dx = -4'sd1; dy =  4'sd0; end  // W
      default: begin dx = -4'sd1; dy = -4'sd1; end  // NW
    endcase
  end

  // Next cell under examination. The cursor stays in 0..7, so next lies in
  // -1..8. Both -1 (1111) and 8 (1000) have bit 3 set, so bit 3 alone marks
  // off-board. That keeps row wrap from happening.
  logic signed [3:0] nx, ny;
  logic              off_board;
  logic [5:0]        cell_idx;
  logic [7:0]        cell_base;
  logic [2:0]        cell_code;
  logic [63:0]       cell_bit;
  logic [7:0]        tgt_base;
  logic [2:0]        tgt_code;
  logic [2:0]        own_code, opp_code;
  logic              tgt_occupied;

  always_comb begin
    nx           = cx_reg + dx;
    ny           = cy_reg + dy;
    off_board    = nx[3] | ny[3];
    cell_idx     = {ny[2:0], nx[2:0]};
    cell_base    = {2'b00, cell_idx} * 8'd3;
    cell_code    = board_reg[cell_base +: 3];
    cell_bit     = 64'd1 << cell_idx;
    tgt_base     = {2'b00, ty_reg, tx_reg} * 8'd3;
    tgt_code     = board_reg[tgt_base +: 3];
    // 110 and 111 are stones. Every other code counts as a free target.
    tgt_occupied = (tgt_code[2:1] == 2'b11);
    own_code     = black_reg ? 3'b111 : 3'b110;
    opp_code     = black_reg ? 3'b110 : 3'b111;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // FSM next-state and strobes.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    end_dir    = 1'b0;
    finish     = 1'b0;
    reject     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (tgt_occupied) begin
          reject     = 1'b1;
          state_next = DONE;
        end else begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (off_board) begin
          end_dir = 1'b1;
        end else if (cell_code == opp_code) begin
          step = 1'b1;
        end else if (cell_code == own_code) begin
          commit  = (run_reg != 64'd0);
          end_dir = 1'b1;
        end else begin
          end_dir = 1'b1;
        end
        if (end_dir && (dir_reg == 3'd7)) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The mask that is committed on the final cycle, including a run that
  // closes in that same cycle.
  logic [63:0] acc_final;
  assign acc_final = commit ? (acc_reg | run_reg) : acc_reg;

  // Datapath.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      board_reg <= '0;
      tx_reg    <= '0;
      ty_reg    <= '0;
      black_reg <= 1'b0;
      dir_reg   <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      acc_reg   <= '0;
      run_reg   <= '0;
      valid_reg <= 1'b0;
      mask_reg  <= '0;
    end else begin
      if (load) begin
        board_reg <= board;
        tx_reg    <= x;
        ty_reg    <= y;
        black_reg <= set_black;
        acc_reg   <= '0;
        run_reg   <= '0;
        dir_reg   <= '0;
        cx_reg    <= {1'b0, x};
        cy_reg    <= {1'b0, y};
      end
      if (step) begin
        run_reg <= run_reg | cell_bit;
        cx_reg  <= nx;
        cy_reg  <= ny;
      end
      if (commit) acc_reg <= acc_reg | run_reg;
      if (end_dir) begin
        run_reg <= '0;
        cx_reg  <= {1'b0, tx_reg};
        cy_reg  <= {1'b0, ty_reg};
        dir_reg <= dir_reg + 3'd1;
      end
      // The results are registered on entry to DONE so that they are
      // already visible while done is high.
      if (reject) begin
        valid_reg <= 1'b0;
        mask_reg  <= '0;
      end
      if (finish) begin
        valid_reg <= (acc_final != 64'd0);
        mask_reg  <= acc_final;
      end
    end
  end

`ifdef REVERSI_FLIP_COUNT_EN
  // len_reg counts the opponent cells in the current run. When the run
  // closes on an own stone, len_reg is added to the total.
  logic [2:0] len_reg;
  logic [6:0] cnt_reg;
  logic [6:0] count_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_reg   <= '0;
      cnt_reg   <= '0;
      count_reg <= '0;
    end else begin
      if (load) begin
        len_reg <= '0;
        cnt_reg <= '0;
      end
      if (step)    len_reg <= len_reg + 3'd1;
      if (commit)  cnt_reg <= cnt_reg + {4'b0000, len_reg};
      if (end_dir) len_reg <= '0;
      if (reject)  count_reg <= '0;
      if (finish)  count_reg <= commit ? (cnt_reg + {4'b0000, len_reg}) : cnt_reg;
    end
  end

  assign flip_count = count_reg;
`else
  assign flip_count = 7'd0;
`endif

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign valid     = valid_reg;
  assign flip_mask = mask_reg;

endmodule

// File: tb/tb_reversi_flip_scan.sv
// ---------------------------------------------------------------------------
// tb_reversi_flip_scan
//
// Self-checking bench for reversi_flip_scan. A table of move vectors is
// applied one after another. The expected result and latency of each start
// are pushed to a scoreboard queue. A negedge monitor pops the queue whenever
// done is seen and compares the outputs. Hand-written sequences cover:
//   - reset in the middle of a scan,
//   - a start pulsed while busy,
//   - a start pulsed during DONE,
//   - back-to-back starts.
// ---------------------------------------------------------------------------
module tb_reversi_flip_scan;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [191:0] board = '0;
  logic [2:0]   x = '0;
  logic [2:0]   y = '0;
  logic         set_black = 1'b0;
  logic         busy, done, valid;
  logic [63:0]  flip_mask;
  logic [6:0]   flip_count;

  reversi_flip_scan dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .board      (board),
    .x          (x),
    .y          (y),
    .set_black  (set_black),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .flip_mask  (flip_mask),
    .flip_count (flip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [191:0] board;
    logic [2:0]   x;
    logic [2:0]   y;
    logic         blk;
    logic         exp_valid;
    logic [63:0]  exp_mask;
    logic [6:0]   exp_count;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic        exp_valid;
    logic [63:0] exp_mask;
    logic [6:0]  exp_count;
    int          exp_lat;
    int          start_cyc;
    int          id;
  } sb_t;

  localparam int NVEC = 11;
  localparam logic [2:0] WHITE = 3'b110;
  localparam logic [2:0] BLACK = 3'b111;
  localparam logic [2:0] ENBL  = 3'b100;

`ifdef REVERSI_FLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  vec_t        vecs[NVEC];
  sb_t         sb_q[$];
  sb_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] prev_mask = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [191:0] put(input logic [191:0] b, input int n,
                                       input logic [2:0] code);
    logic [191:0] r;
    r = b;
    r[3*n +: 3] = code;
    return r;
  endfunction

  function automatic logic [6:0] cexp(input int n);
    return CNT_EN ? 7'(n) : 7'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding start.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn %0d: valid=%0d mask=%h count=%0d latency=%0d",
                 mon_e.id, valid, flip_mask, flip_count, cyc - mon_e.start_cyc);
        check("valid", {63'd0, valid}, {63'd0, mon_e.exp_valid});
        check("flip_mask", flip_mask, mon_e.exp_mask);
        check("flip_count", {57'd0, flip_count}, {57'd0, mon_e.exp_count});
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.exp_lat));
        prev_mask = mon_e.exp_mask;
      end
    end
  end

  // Returns #1 after the edge that closes the DONE cycle, which is the first
  // cycle in which a new start may be accepted.
  task automatic wait_idle();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d outstanding results, required 0", sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    check("busy_idle", {63'd0, busy}, 64'd0);
    board     = v.board;
    x         = v.x;
    y         = v.y;
    set_black = v.blk;
    start     = 1'b1;
    sb_q.push_back('{v.exp_valid, v.exp_mask, v.exp_count, v.exp_lat, cyc, id});
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("mask_held", flip_mask, prev_mask);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] b0, b;

    // Standard opening position.
    b0 = '0;
    b0 = put(b0, 27, WHITE);
    b0 = put(b0, 28, BLACK);
    b0 = put(b0, 35, BLACK);
    b0 = put(b0, 36, WHITE);

    vecs[0] = '{b0, 3'd2, 3'd3, 1'b1, 1'b1, 64'd1 << 27, cexp(1), 11};
    vecs[1] = '{b0, 3'd0, 3'd0, 1'b1, 1'b0, 64'd0, cexp(0), 10};
    vecs[2] = '{b0, 3'd3, 3'd3, 1'b1, 1'b0, 64'd0, cexp(0), 2};
    // Black stone at 28 is occupied as well.
    vecs[3] = '{b0, 3'd4, 3'd3, 1'b0, 1'b0, 64'd0, cexp(0), 2};
    // White to move at (4,2): the S run flips 28.
    vecs[4] = '{b0, 3'd4, 3'd2, 1'b0, 1'b1, 64'd1 << 28, cexp(1), 11};
    // Row wrap: E from (7,3) must not reach cells 32 and 33.
    b = '0;
    b = put(b, 32, WHITE);
    b = put(b, 33, BLACK);
    vecs[5] = '{b, 3'd7, 3'd3, 1'b1, 1'b0, 64'd0, cexp(0), 10};
    // Three runs from the corner.
    b = '0;
    b = put(b, 1, WHITE);
    b = put(b, 8, WHITE);
    b = put(b, 9, WHITE);
    b = put(b, 2, BLACK);
    b = put(b, 16, BLACK);
    b = put(b, 18, BLACK);
    vecs[6] = '{b, 3'd0, 3'd0, 1'b1, 1'b1,
                (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9), cexp(3), 13};
    // A run of seven opponents that runs off the board is discarded.
    b = '0;
    for (int i = 1; i < 8; i++) b = put(b, i, WHITE);
    vecs[7] = '{b, 3'd0, 3'd0, 1'b1, 1'b0, 64'd0, cexp(0), 17};
    // A run that ends on an enable cell is discarded.
    b = '0;
    b = put(b, 1, WHITE);
    b = put(b, 2, ENBL);
    vecs[8] = '{b, 3'd0, 3'd0, 1'b1, 1'b0, 64'd0, cexp(0), 11};
    // Enable and undefined target codes count as free.
    vecs[9]  = '{put(b0, 26, ENBL), 3'd2, 3'd3, 1'b1, 1'b1, 64'd1 << 27, cexp(1), 11};
    vecs[10] = '{put(b0, 26, 3'b001), 3'd2, 3'd3, 1'b1, 1'b1, 64'd1 << 27, cexp(1), 11};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_mask", flip_mask, 64'd0);
    check("rst_count", {57'd0, flip_count}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, issued back to back. Each start lands in the
    // cycle right after the previous DONE.
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset in cycle 5 of a running scan: the scan is abandoned and no done
    // is produced.
    board = vecs[0].board; x = vecs[0].x; y = vecs[0].y; set_black = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_mask", flip_mask, 64'd0);
    check("midrst_count", {57'd0, flip_count}, 64'd0);
    prev_mask = '0;
    repeat (20) @(posedge clk);
    #1;

    // New start after reset. Extra starts in cycle 2 (busy) and in cycle 11
    // (DONE) must be ignored.
    check("busy_idle", {63'd0, busy}, 64'd0);
    board = vecs[0].board; x = vecs[0].x; y = vecs[0].y; set_black = 1'b1;
    start = 1'b1;
    sb_q.push_back('{vecs[0].exp_valid, vecs[0].exp_mask, vecs[0].exp_count,
                     vecs[0].exp_lat, cyc, 100});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    x = 3'd0; y = 3'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("done_in_cycle_11", {63'd0, done}, 64'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_idle", {63'd0, busy}, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    // One more back-to-back vector after the ignored starts.
    wait_idle();
    run_vec(vecs[6], 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
